// File: rtl/mpsoc_msi_wb_master_engine.sv
// Wishbone B3 master engine: turns one (addr, dir, length) command into a classic or
// linear incrementing burst, handling ack/err/rty with a bounded retry count.
module mpsoc_msi_wb_master_engine #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned MAXLEN  = 16,
  parameter int unsigned RTY_MAX = 4,
  localparam int unsigned LW     = $clog2(MAXLEN)
) (
  input  logic            wb_clk,
  input  logic            wb_rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [LW-1:0]   cmd_len,
  input  logic [DW-1:0]   wr_data,
  input  logic [DW/8-1:0] wr_sel,
  output logic            wr_ready,
  output logic [DW-1:0]   rd_data,
  output logic            rd_valid,
  output logic            done,
  output logic            done_err,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic [2:0]      wb_cti_o,
  output logic [1:0]      wb_bte_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_rty_i
);

  localparam int unsigned RW = $clog2(RTY_MAX + 1);
  localparam logic [2:0] CtiClassic = 3'b000;
  localparam logic [2:0] CtiIncr    = 3'b010;
  localparam logic [2:0] CtiEnd     = 3'b111;

  typedef enum logic [1:0] {StIdle, StBus, StRetry, StDone} state_e;

  state_e            state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic [DW/8-1:0]   sel_q, sel_d;
  logic [2:0]        cti_q, cti_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     rty_q, rty_d;
  logic [DW-1:0]     rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_ready_q, wr_ready_d;
  logic              done_q, done_d;
  logic              done_err_q, done_err_d;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q    <= StIdle;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      sel_q      <= '0;
      cti_q      <= CtiClassic;
      len_q      <= '0;
      cnt_q      <= '0;
      rty_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_ready_q <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      sel_q      <= sel_d;
      cti_q      <= cti_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      rty_q      <= rty_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_ready_q <= wr_ready_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    adr_d      = adr_q;
    sel_d      = sel_q;
    cti_d      = cti_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    rty_d      = rty_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wr_ready_d = 1'b0;
    done_d     = 1'b0;
    done_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d = StBus;
          cyc_d   = 1'b1;
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          len_d   = cmd_len;
          cnt_d   = '0;
          rty_d   = '0;
          sel_d   = cmd_we ? '0 : '1;
          cti_d   = (cmd_len == '0) ? CtiClassic : CtiIncr;
        end
      end
      StBus: begin
        // Priority err > rty > ack; responses only count while the strobe is up.
        if (cyc_q && wb_err_i) begin
          state_d    = StDone;
          cyc_d      = 1'b0;
          done_d     = 1'b1;
          done_err_d = 1'b1;
        end else if (cyc_q && wb_rty_i) begin
          cyc_d = 1'b0;
          if (rty_q == RW'(RTY_MAX - 1)) begin
            state_d    = StDone;
            done_d     = 1'b1;
            done_err_d = 1'b1;
          end else begin
            state_d = StRetry;
            rty_d   = rty_q + RW'(1);
          end
        end else if (cyc_q && wb_ack_i) begin
          rty_d      = '0;
          rd_valid_d = ~we_q;
          wr_ready_d = we_q;
          if (!we_q) begin
            rd_data_d = wb_dat_i;
          end
          if (cnt_q == len_q) begin
            state_d = StDone;
            cyc_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + LW'(1);
            adr_d = adr_q + AW'(DW / 8);
            cti_d = ((cnt_q + LW'(1)) == len_q) ? CtiEnd : CtiIncr;
          end
        end
      end
      StRetry: begin
        state_d = StBus;
        cyc_d   = 1'b1;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cyc_d   = 1'b0;
      end
    endcase
  end

  assign cmd_ready = (state_q == StIdle);
  assign wr_ready  = wr_ready_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign done_err  = done_err_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = wr_data;
  assign wb_sel_o  = we_q ? wr_sel : sel_q;
  assign wb_we_o   = we_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_cti_o  = cti_q;
  assign wb_bte_o  = 2'b00;

endmodule

// File: tb/tb_mpsoc_msi_wb_master_engine.sv
// Scoreboarded bench: a command-level model predicts bus attempts, read beats, write
// handshakes and completion; a scripted slave and an output monitor check against them.
module tb_mpsoc_msi_wb_master_engine;

  localparam int RTY_MAX = 4;

  typedef struct {
    logic [31:0] adr;
    logic [2:0]  cti;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] rdata;
    int          waits;
    int          kind;   // 0 ack, 1 err, 2 rty
  } bus_t;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_adr = '0;
  logic [3:0]  cmd_len = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_sel = '0;
  logic        wr_ready, rd_valid, done, done_err;
  logic [31:0] rd_data, wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;

  int checks = 0;
  int errors = 0;

  bus_t        bus_q[$];
  logic [31:0] rd_q[$];
  int          wr_q[$];
  logic        done_q[$];

  logic [31:0] wdata[17];
  logic [3:0]  wsel[17];
  int          wr_idx = 0;
  int          wr_seen = 0;
  bit          wr_adv = 0;
  bit          active = 0;
  int          wait_left = 0;
  bus_t        cur;

  mpsoc_msi_wb_master_engine #(
    .DW(32), .AW(32), .MAXLEN(16), .RTY_MAX(RTY_MAX)
  ) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_sel(wr_sel), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .done_err(done_err),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  // Scripted slave: one queue entry per bus attempt; checks the request every strobed cycle.
  always @(negedge wb_clk) begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_rty_i = 1'b0;
    wr_adv   = 1'b0;
    if (wb_rst) begin
      active = 0;
    end else if (wb_cyc_o && wb_stb_o) begin
      if (!active) begin
        if (bus_q.size() == 0) fail("unexpected bus cycle");
        else begin
          cur = bus_q.pop_front();
          active = 1;
          wait_left = cur.waits;
        end
      end
      if (active) begin
        chk("wb_adr_o", wb_adr_o, cur.adr);
        chk("wb_cti_o", 32'(wb_cti_o), 32'(cur.cti));
        chk("wb_we_o", 32'(wb_we_o), 32'(cur.we));
        chk("wb_sel_o", 32'(wb_sel_o), 32'(cur.sel));
        chk("wb_bte_o", 32'(wb_bte_o), 32'd0);
        if (cur.we) chk("wb_dat_o", wb_dat_o, cur.dat);
        if (wait_left > 0) begin
          wait_left--;
        end else begin
          wb_dat_i = (cur.kind == 0) ? cur.rdata : $urandom;
          wb_ack_i = (cur.kind == 0);
          wb_err_i = (cur.kind == 1);
          wb_rty_i = (cur.kind == 2);
          wr_adv   = cur.we && (cur.kind == 0);
          active   = 0;
        end
      end
    end else if ($urandom_range(0, 9) == 0) begin
      // Stray responses while the strobe is low must be ignored.
      wb_ack_i = 1'($urandom);
      wb_err_i = 1'($urandom);
      wb_rty_i = 1'($urandom);
      wb_dat_i = $urandom;
    end
  end

  // Write-data producer advances after each acked write beat.
  always @(posedge wb_clk) begin
    if (wr_adv) begin
      #1;
      wr_idx++;
      wr_data = wdata[wr_idx];
      wr_sel  = wsel[wr_idx];
    end
  end

  always @(negedge wb_clk) begin
    if (!wb_rst) begin
      if (rd_valid) begin
        if (rd_q.size() == 0) fail("spurious rd_valid");
        else chk("rd_data", rd_data, rd_q.pop_front());
      end
      if (wr_ready) begin
        if (wr_q.size() == 0) fail("spurious wr_ready");
        else begin
          chk("wr_ready beat", 32'(wr_seen), 32'(wr_q.pop_front()));
          wr_seen++;
        end
      end
      if (done) begin
        if (done_q.size() == 0) fail("spurious done");
        else chk("done_err", 32'(done_err), 32'(done_q.pop_front()));
      end else if (done_err) begin
        fail("done_err without done");
      end
    end
  end

  // Reference model: walks the response script beat by beat and predicts all outcomes.
  // mode 0 random, 1 zero-wait acks, 2 retry forever, 3 err on beat 1, 4 two retries first.
  task automatic issue(input bit we, input logic [31:0] adr, input int len, input int mode);
    int   b = 0, r = 0, a = 0, x;
    bit   fin = 0;
    bus_t e;
    for (int i = 0; i < 17; i++) begin
      wdata[i] = $urandom;
      wsel[i]  = 4'($urandom);
    end
    while (!fin) begin
      e.adr   = adr + 32'(4 * b);
      e.cti   = (len == 0) ? 3'b000 : ((b == len) ? 3'b111 : 3'b010);
      e.we    = we;
      e.sel   = we ? wsel[b] : 4'hf;
      e.dat   = wdata[b];
      e.rdata = $urandom;
      e.waits = 0;
      if (mode == 0 && $urandom_range(0, 3) == 0) e.waits = $urandom_range(1, 3);
      case (mode)
        1: e.kind = 0;
        2: e.kind = 2;
        3: e.kind = (b == 1) ? 1 : 0;
        4: e.kind = (a < 2) ? 2 : 0;
        default: begin
          x = $urandom_range(0, 99);
          e.kind = (x < 4) ? 1 : ((x < 16) ? 2 : 0);
        end
      endcase
      bus_q.push_back(e);
      a++;
      if (e.kind == 1) begin
        done_q.push_back(1'b1);
        fin = 1;
      end else if (e.kind == 2) begin
        r++;
        if (r == RTY_MAX) begin
          done_q.push_back(1'b1);
          fin = 1;
        end
      end else begin
        r = 0;
        if (we) wr_q.push_back(b);
        else rd_q.push_back(e.rdata);
        if (b == len) begin
          done_q.push_back(1'b0);
          fin = 1;
        end
        b++;
      end
    end
    wr_idx  = 0;
    wr_data = wdata[0];
    wr_sel  = wsel[0];
    wr_seen = 0;
    for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge wb_clk);
    chk("cmd_ready before issue", 32'(cmd_ready), 32'd1);
    @(negedge wb_clk);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_len   = 4'(len);
    @(posedge wb_clk);
    #1;
    // Held for one more cycle with junk: a busy engine must not take it.
    cmd_we  = 1'($urandom);
    cmd_adr = $urandom;
    cmd_len = 4'($urandom);
    @(posedge wb_clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic flush();
    bus_q.delete();
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
  endtask

  task automatic finish_cmd(input int len, input int mode);
    int lat = 1;
    bit seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge wb_clk);
      lat++;
      seen = done;
    end
    if (!seen) begin
      fail("done timeout");
      wb_rst = 1'b1;
      flush();
      @(negedge wb_clk);
      wb_rst = 1'b0;
    end else begin
      if (mode == 1) chk("zero-wait latency", 32'(lat), 32'(len + 2));
      chk("cyc low at done", 32'(wb_cyc_o), 32'd0);
      @(negedge wb_clk);
      chk("cmd_ready after done", 32'(cmd_ready), 32'd1);
      chk("scoreboard drained", 32'(bus_q.size() + rd_q.size() + wr_q.size() + done_q.size()),
          32'd0);
    end
  endtask

  task automatic run(input bit we, input logic [31:0] adr, input int len, input int mode);
    issue(we, adr, len, mode);
    finish_cmd(len, mode);
  endtask

  initial begin
    int len, mode;
    logic [31:0] adr;
    #12;
    chk("reset cyc", 32'(wb_cyc_o), 32'd0);
    chk("reset stb", 32'(wb_stb_o), 32'd0);
    chk("reset we", 32'(wb_we_o), 32'd0);
    chk("reset adr", wb_adr_o, 32'd0);
    chk("reset sel", 32'(wb_sel_o), 32'd0);
    chk("reset cti", 32'(wb_cti_o), 32'd0);
    chk("reset rd_data", rd_data, 32'd0);
    chk("reset pulses", {28'd0, rd_valid, wr_ready, done, done_err}, 32'd0);
    chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge wb_clk);
    wb_rst = 1'b0;

    run(1'b0, 32'h100, 0, 1);
    run(1'b1, 32'h200, 3, 1);
    run(1'b0, 32'h300, 7, 0);
    run(1'b1, 32'h400, 3, 3);
    run(1'b0, 32'h500, 0, 4);
    run(1'b0, 32'h600, 0, 2);
    run(1'b1, 32'hFFFF_FFF8, 5, 1);

    for (int n = 0; n < 60; n++) begin
      len  = $urandom_range(0, 15);
      mode = $urandom_range(0, 9);
      mode = (mode < 5) ? 0 : ((mode < 7) ? 1 : ((mode == 7) ? 4 : ((mode == 8) ? 3 : 2)));
      adr  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFE0 + 32'(4 * $urandom_range(0, 7))
                                          : ($urandom & 32'hFFFF_FFFC);
      run(1'($urandom), adr, len, mode);
    end

    // Reset in the middle of a 4-beat burst.
    issue(1'b1, 32'h700, 3, 1);
    @(posedge wb_clk);
    #1 wb_rst = 1'b1;
    #1;
    chk("mid-burst reset cyc", 32'(wb_cyc_o), 32'd0);
    chk("mid-burst reset stb", 32'(wb_stb_o), 32'd0);
    chk("mid-burst reset cmd_ready", 32'(cmd_ready), 32'd1);
    flush();
    repeat (2) @(negedge wb_clk);
    wb_rst = 1'b0;
    @(negedge wb_clk);
    chk("cmd_ready after reset", 32'(cmd_ready), 32'd1);
    run(1'b0, 32'h800, 3, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
